// File: rtl/udp_encoder_pkg.sv
// Shared definitions for the UDP transmit framer and its receive-side counterpart.
// Gray-coded FSM states, frame geometry and message-type codes.
package udp_encoder_pkg;

  localparam logic [2:0] S_IDLE = 3'b000;
  localparam logic [2:0] S_REQ  = 3'b001;
  localparam logic [2:0] S_HDR  = 3'b011;
  localparam logic [2:0] S_DATA = 3'b010;
  localparam logic [2:0] S_DONE = 3'b110;

  localparam int unsigned UDP_HDR_LEN = 8;
  localparam int unsigned WORD_BYTES  = 9;

  // Message-type codes understood by both the TX framer and the RX decoder.
  typedef enum logic [1:0] {
    MSG_NONE = 2'd0,
    MSG_DATA = 2'd1,
    MSG_CTRL = 2'd2,
    MSG_ACK  = 2'd3
  } udp_msg_e;

  function automatic logic [15:0] udp_len(input int unsigned words);
    return 16'(UDP_HDR_LEN + WORD_BYTES * words);
  endfunction

endpackage

// File: rtl/udp_tx_fifo.sv
// Word FIFO ahead of the UDP framer; registered full/empty/count and a registered ready.
// DEPTH must be a power of two and at least 2 so pointers wrap naturally.
module udp_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 72
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       push_i,
  input  logic [W-1:0]               data_i,
  input  logic                       pop_i,
  output logic [W-1:0]               data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       rdy_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          full_q, empty_q, rdy_q;
  logic          do_push, do_pop;

  assign do_push = push_i & ~full_q;
  assign do_pop  = pop_i & ~empty_q;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      rdy_q    <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == FULL_CNT);
      empty_q <= (count_d == '0);
      rdy_q   <= (count_d != FULL_CNT);
    end
  end

  // Storage is not reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign rdy_o   = rdy_q;

endmodule

// File: rtl/udp_encoder.sv
// Transmit-side UDP framer: buffers 72-bit words and streams one datagram per WORDS_PER_PKT words
// byte-serially (8-byte header, then payload MSB byte first).
//
// state  | meaning
// IDLE   | wait until a full datagram of words is buffered
// REQ    | udp_req_o high, waiting for the IP encoder grant
// HDR    | emit the 8 header bytes
// DATA   | emit 9 bytes per payload word, popping each word on its first byte
// DONE   | one-cycle udp_done_o pulse, no data
module udp_encoder #(
  parameter logic [15:0] SRC_UDP_PORT  = 16'd10_001,
  parameter int unsigned WORDS_PER_PKT = 1,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [71:0] in_data_i,
  input  logic        in_data_vld_i,
  output logic        in_data_rdy_o,
  input  logic [15:0] dst_port_i,
  output logic        udp_req_o,
  input  logic        udp_ack_i,
  output logic [15:0] udp_len_o,
  output logic [7:0]  out_data_o,
  output logic        out_data_vld_o,
  output logic        udp_done_o
);
  import udp_encoder_pkg::*;

  localparam int unsigned   CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0]   LEN       = udp_len(WORDS_PER_PKT);
  localparam logic [CW-1:0] PKT_WORDS = CW'(WORDS_PER_PKT);
  localparam logic [7:0]    LAST_WORD = 8'(WORDS_PER_PKT - 1);
  localparam logic [3:0]    LAST_HDR  = 4'(UDP_HDR_LEN - 1);
  localparam logic [3:0]    LAST_BYTE = 4'(WORD_BYTES - 1);

  logic [2:0]    state_q, state_d;
  logic [15:0]   dst_q, dst_d;
  logic [3:0]    byte_cnt_q, byte_cnt_d;
  logic [7:0]    word_cnt_q, word_cnt_d;
  logic [71:0]   shift_q, shift_d;
  logic          fifo_push, fifo_pop;
  logic [71:0]   fifo_head;
  logic [CW-1:0] fifo_count;
  logic [7:0]    hdr_byte;

  assign fifo_push = in_data_vld_i & in_data_rdy_o;

  udp_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (72)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (fifo_push),
    .data_i  (in_data_i),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .count_o (fifo_count),
    .rdy_o   (in_data_rdy_o)
  );

  // Checksum bytes are zero: the UDP checksum is not computed.
  always_comb begin
    hdr_byte = 8'h00;
    case (byte_cnt_q[2:0])
      3'd0:    hdr_byte = SRC_UDP_PORT[15:8];
      3'd1:    hdr_byte = SRC_UDP_PORT[7:0];
      3'd2:    hdr_byte = dst_q[15:8];
      3'd3:    hdr_byte = dst_q[7:0];
      3'd4:    hdr_byte = LEN[15:8];
      3'd5:    hdr_byte = LEN[7:0];
      default: hdr_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    dst_d          = dst_q;
    byte_cnt_d     = byte_cnt_q;
    word_cnt_d     = word_cnt_q;
    shift_d        = shift_q;
    fifo_pop       = 1'b0;
    out_data_o     = 8'h00;
    out_data_vld_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fifo_count >= PKT_WORDS) begin
          dst_d   = dst_port_i;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (udp_ack_i) begin
          state_d    = S_HDR;
          byte_cnt_d = 4'd0;
          word_cnt_d = 8'd0;
        end
      end
      S_HDR: begin
        out_data_vld_o = 1'b1;
        out_data_o     = hdr_byte;
        if (byte_cnt_q == LAST_HDR) begin
          byte_cnt_d = 4'd0;
          state_d    = S_DATA;
        end else begin
          byte_cnt_d = byte_cnt_q + 4'd1;
        end
      end
      S_DATA: begin
        out_data_vld_o = 1'b1;
        // The head word is driven straight from the FIFO on its first byte, then shifted out.
        if (byte_cnt_q == 4'd0) begin
          fifo_pop   = 1'b1;
          out_data_o = fifo_head[71:64];
          shift_d    = {fifo_head[63:0], 8'h00};
        end else begin
          out_data_o = shift_q[71:64];
          shift_d    = {shift_q[63:0], 8'h00};
        end
        if (byte_cnt_q == LAST_BYTE) begin
          byte_cnt_d = 4'd0;
          if (word_cnt_q == LAST_WORD) state_d = S_DONE;
          else                         word_cnt_d = word_cnt_q + 8'd1;
        end else begin
          byte_cnt_d = byte_cnt_q + 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      dst_q      <= 16'h0000;
      byte_cnt_q <= 4'd0;
      word_cnt_q <= 8'd0;
      shift_q    <= 72'h0;
    end else begin
      state_q    <= state_d;
      dst_q      <= dst_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      shift_q    <= shift_d;
    end
  end

  assign udp_req_o  = (state_q == S_REQ);
  assign udp_len_o  = udp_req_o ? LEN : 16'h0000;
  assign udp_done_o = (state_q == S_DONE);

endmodule
